// File: rtl/duck_game_pkg.sv
// rtl/duck_game_pkg.sv - shared state codes and screen constants for the duck-hunt game flow
package duck_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_MISS = 3'd3,
    ST_NEXT = 3'd4,
    ST_OVER = 3'd5
  } state_t;

  localparam int H_VISIBLE      = 640;
  localparam int V_VISIBLE      = 480;
  localparam int FRAME_LINE_DEF = V_VISIBLE;
  localparam int COUNT_W        = $clog2(H_VISIBLE);
  localparam int SCORE_W        = 8;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - registered one-cycle pulse at the start of the frame line
module frame_tick_gen
  import duck_game_pkg::*;
#(
  parameter int FRAME_LINE = FRAME_LINE_DEF
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] hcount,
  input  logic [COUNT_W-1:0] vcount,
  output logic               frame_tick
);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (vcount == COUNT_W'(FRAME_LINE)) && (hcount == '0);
    end
  end

endmodule

// File: rtl/duck_game_sequencer.sv
// rtl/duck_game_sequencer.sv - round sequencing, fire gating, hit detection and scoring
// Optional early game over on misses: DUCK_SEQ_MISS_LIMIT_EN
module duck_game_sequencer
  import duck_game_pkg::*;
#(
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int HOLD_FRAMES     = 30,
  parameter int FRAME_LINE      = FRAME_LINE_DEF
`ifdef DUCK_SEQ_MISS_LIMIT_EN
  ,
  parameter int MISS_LIMIT      = 3
`endif
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] hcount,
  input  logic [COUNT_W-1:0] vcount,
  input  logic               fire,
  input  logic               duck_draw,
  input  logic               shot_draw,
  input  logic               shot_active,
  output logic               fire_gate,
  output logic               duck_run,
  output logic               duck_respawn,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         shots_left,
  output logic [3:0]         duck_idx
);

  state_t               state_q, state_d;
  logic                 fire_q, fire_edge, frame_tick;
  logic                 hit_latch, hit_d;
  logic [5:0]           hold_cnt, hold_d;
  logic [SCORE_W-1:0]   score_d;
  logic [1:0]           shots_d;
  logic [3:0]           idx_d;
  logic                 gate_d, respawn_d, game_end;

  frame_tick_gen #(.FRAME_LINE(FRAME_LINE)) u_frame_tick_gen (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .frame_tick (frame_tick)
  );

  assign fire_edge = fire & ~fire_q;
  assign state     = state_q;

`ifdef DUCK_SEQ_MISS_LIMIT_EN
  logic [3:0] miss_cnt, miss_d;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      miss_cnt <= '0;
    end else begin
      miss_cnt <= miss_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    score_d   = score;
    shots_d   = shots_left;
    idx_d     = duck_idx;
    hold_d    = hold_cnt;
    hit_d     = hit_latch;
    gate_d    = 1'b0;
    respawn_d = 1'b0;
    game_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fire_edge) begin
          score_d   = '0;
          idx_d     = '0;
          shots_d   = 2'(SHOTS_PER_DUCK);
          respawn_d = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (fire_edge && shots_left != 2'd0 && !shot_active) begin
          gate_d  = 1'b1;
          shots_d = shots_left - 2'd1;
        end
        if (duck_draw && shot_draw) hit_d = 1'b1;
        // A hit recorded this frame takes priority over running out of shots
        if (frame_tick) begin
          if (hit_latch) begin
            score_d = sat_inc(score);
            state_d = ST_HIT;
          end else if (shots_left == 2'd0 && !shot_active) begin
            state_d = ST_MISS;
          end
        end
      end
      ST_HIT, ST_MISS: begin
        if (frame_tick) begin
          if (hold_cnt + 6'd1 == 6'(HOLD_FRAMES)) state_d = ST_NEXT;
          else                                    hold_d  = hold_cnt + 6'd1;
        end
      end
      ST_NEXT: begin
        idx_d    = duck_idx + 4'd1;
        game_end = (idx_d == 4'(DUCKS_PER_ROUND));
`ifdef DUCK_SEQ_MISS_LIMIT_EN
        game_end = game_end || (miss_cnt >= 4'(MISS_LIMIT));
`endif
        if (game_end) begin
          state_d = ST_OVER;
        end else begin
          respawn_d = 1'b1;
          shots_d   = 2'(SHOTS_PER_DUCK);
          state_d   = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (fire_edge) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_tick) hit_d = 1'b0;
    if (state_d != state_q) begin
      hit_d  = 1'b0;
      hold_d = '0;
    end

`ifdef DUCK_SEQ_MISS_LIMIT_EN
    miss_d = miss_cnt;
    if (state_q == ST_IDLE)                             miss_d = '0;
    else if (state_d == ST_MISS && state_q != ST_MISS) miss_d = miss_cnt + 4'd1;
`endif
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fire_q       <= 1'b0;
      hit_latch    <= 1'b0;
      hold_cnt     <= '0;
      score        <= '0;
      shots_left   <= 2'(SHOTS_PER_DUCK);
      duck_idx     <= '0;
      fire_gate    <= 1'b0;
      duck_run     <= 1'b0;
      duck_respawn <= 1'b0;
    end else begin
      state_q      <= state_d;
      fire_q       <= fire;
      hit_latch    <= hit_d;
      hold_cnt     <= hold_d;
      score        <= score_d;
      shots_left   <= shots_d;
      duck_idx     <= idx_d;
      fire_gate    <= gate_d;
      duck_run     <= (state_d == ST_PLAY);
      duck_respawn <= respawn_d;
    end
  end

endmodule
